// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector, compares dut_f.
// Optional SWEEP_GRAY_EN: step vectors in reflected Gray order.
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter logic [(1<<N_IN)-1:0] TRUTH = 16'h0000,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN:0] LAST  = (N_IN+1)'(NV - 1);
  localparam logic [N_IN:0] ONE   = (N_IN+1)'(1);
  localparam logic [CW-1:0] CLAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [N_IN:0]   idx, idx_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [N_IN-1:0] vec_nx;
  logic            busy_nx, done_nx, pass_nx;
  logic [N_IN:0]   err_nx;
  logic [N_IN-1:0] ff_nx;
  logic            fv_nx;
  logic            mismatch;

  function automatic logic [N_IN-1:0] map_vec(input logic [N_IN:0] i);
`ifdef SWEEP_GRAY_EN
    return i[N_IN-1:0] ^ (i[N_IN-1:0] >> 1);
`else
    return i[N_IN-1:0];
`endif
  endfunction

  // Case inequality so an X on dut_f counts as a mismatch in simulation.
  assign mismatch = (dut_f !== TRUTH[vec_out]);

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    vec_nx   = vec_out;
    busy_nx  = busy;
    done_nx  = done;
    pass_nx  = pass;
    err_nx   = err_count;
    ff_nx    = first_fail;
    fv_nx    = fail_valid;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = S_SETTLE;
          idx_nx   = '0;
          cnt_nx   = '0;
          vec_nx   = '0;
          busy_nx  = 1'b1;
          done_nx  = 1'b0;
          pass_nx  = 1'b0;
          err_nx   = '0;
          ff_nx    = '0;
          fv_nx    = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt == CLAST) begin
          state_nx = S_CHECK;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_nx = err_count + ONE;
          if (!fail_valid) begin
            ff_nx = vec_out;
            fv_nx = 1'b1;
          end
        end
        if (idx == LAST) begin
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (err_count == '0) && !mismatch;
        end else begin
          state_nx = S_SETTLE;
          idx_nx   = idx + ONE;
          vec_nx   = map_vec(idx + ONE);
          cnt_nx   = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      vec_out    <= vec_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      pass       <= pass_nx;
      err_count  <= err_nx;
      first_fail <= ff_nx;
      fail_valid <= fv_nx;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper (SETTLE=1 and SETTLE=3 instances).
// Expected results come from a visit-order model of the tested block.
module tb_truth_table_sweeper;

  localparam logic [15:0] TT = 16'hA5C3;

  typedef struct {
    int err;
    int ff;
    int fv;
    int ps;
    int cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] mask = '0;
  logic stuck = 1'b0;

  logic [3:0] vec_a, ff_a, vec_b, ff_b;
  logic [4:0] err_a, err_b;
  logic f_a, busy_a, done_a, pass_a, fv_a;
  logic f_b, busy_b, done_b, pass_b, fv_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int order[16];
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign f_a = stuck ? 1'b0 : (TT[vec_a] ^ mask[vec_a]);
  assign f_b = stuck ? 1'b0 : (TT[vec_b] ^ mask[vec_b]);

  truth_table_sweeper #(.N_IN(4), .TRUTH(TT), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_a),
    .dut_f(f_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail(ff_a), .fail_valid(fv_a)
  );

  truth_table_sweeper #(.N_IN(4), .TRUTH(TT), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_b),
    .dut_f(f_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail(ff_b), .fail_valid(fv_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int settle);
    exp_t e;
    int v;
    logic f;
    e = '{0, 0, 0, 0, 0};
    for (int k = 0; k < 16; k++) begin
      v = order[k];
      f = stuck ? 1'b0 : (TT[v] ^ mask[v]);
      if (f != TT[v]) begin
        if (e.fv == 0) begin
          e.ff = v;
          e.fv = 1;
        end
        e.err++;
      end
    end
    e.ps = (e.err == 0) ? 1 : 0;
    e.cycles = 16 * (settle + 1);
    return e;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic issue_start();
    qa.push_back(model(1));
    qb.push_back(model(3));
    pulse_start();
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_timeout", qa.size() + qb.size(), 0);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_vec(input logic [3:0] v);
    int t;
    t = 0;
    while (vec_a != v && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_vec_timeout", (vec_a == v), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_zero"},
        {vec_a, busy_a, done_a, pass_a, err_a, ff_a, fv_a}, 0);
    chk({tag, "_b_zero"},
        {vec_b, busy_b, done_b, pass_b, err_b, ff_b, fv_b}, 0);
  endtask

  // Monitor for the SETTLE=1 instance: vector order and sweep results.
  logic pb_a = 1'b0, pd_a = 1'b0;
  logic [3:0] pv_a = '0;
  int t0_a = 0, step_a = 0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    int st;
    st = step_a;
    if (busy_a && !pb_a) begin
      st = 0;
      t0_a <= cyc;
      chk("a_vec_first", vec_a, order[0]);
    end else if (busy_a && vec_a != pv_a) begin
      st = step_a + 1;
      chk("a_vec_step", vec_a, order[st & 15]);
    end
    step_a <= st;
    if (done_a && !pd_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_err_count", err_a, e.err);
        chk("a_fail_valid", fv_a, e.fv);
        chk("a_first_fail", ff_a, e.ff);
        chk("a_pass", pass_a, e.ps);
        chk("a_cycles", cyc - t0_a, e.cycles);
        chk("a_busy_at_done", busy_a, 0);
        chk("a_steps", st, 15);
      end
    end
    pb_a <= busy_a;
    pd_a <= done_a;
    pv_a <= vec_a;
  end

  // Monitor for the SETTLE=3 instance: sweep results and duration.
  logic pb_b = 1'b0, pd_b = 1'b0;
  int t0_b = 0;
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (busy_b && !pb_b) t0_b <= cyc;
    if (done_b && !pd_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_err_count", err_b, e.err);
        chk("b_fail_valid", fv_b, e.fv);
        chk("b_first_fail", ff_b, e.ff);
        chk("b_pass", pass_b, e.ps);
        chk("b_cycles", cyc - t0_b, e.cycles);
      end
    end
    pb_b <= busy_b;
    pd_b <= done_b;
  end

  initial begin
    int seen;
    for (int k = 0; k < 16; k++) begin
`ifdef SWEEP_GRAY_EN
      order[k] = k ^ (k >> 1);
`else
      order[k] = k;
`endif
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("idle");

    // golden
    mask = '0;
    issue_start();
    wait_idle(200);

    // faults at vectors 5 and 11
    mask = 16'h0820;
    issue_start();
    wait_idle(200);

    // stuck-at-0, started from DONE: results clear on accept
    mask = '0;
    stuck = 1'b1;
    issue_start();
    chk("restart_err_clear", err_a, 0);
    chk("restart_fv_clear", fv_a, 0);
    chk("restart_done_clear", done_a, 0);
    chk("restart_busy", busy_a, 1);
    wait_idle(200);
    stuck = 1'b0;

    // start re-pulsed mid-sweep is ignored
    issue_start();
    wait_vec(4'd7);
    pulse_start();
    wait_idle(200);

    // randomized fault masks
    for (int r = 0; r < 6; r++) begin
      mask = (r == 0) ? 16'h8000 : 16'($urandom());
      issue_start();
      wait_idle(200);
    end
    mask = '0;

    // reset mid-sweep abandons it
    issue_start();
    wait_vec(4'd9);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_a || done_b || busy_a || busy_b) seen = 1;
    end
    chk("no_done_after_reset", seen, 0);

    // normal sweep after reset
    issue_start();
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Synthesizable, parametrised exhaustive test-vector engine for N-input single-output combinational blocks, such as the K-map lab functions.
- Drives every input combination onto the DUT and waits a programmable settle time.
- Compares the DUT output against an expected truth table given as a parameter, then reports a mismatch count, the first failing vector, and pass/fail.
- Sits beside the DUT in lab top-levels and replaces hand-written per-vector stimulus.

Parameters:
N_IN, 4, number of DUT inputs (1..8); vector space is 2^N_IN.
TRUTH, 16'h0000, expected output table, width 2^N_IN; bit k = expected F for input vector k.
SETTLE, 1, cycles between driving a vector and sampling dut_f (>=1).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin a sweep
vec_out  output  N_IN  vector driven to DUT inputs, MSB = A
dut_f  input  1  DUT output under test
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until next accepted start or reset
pass  output  1  done && err_count==0
err_count  output  N_IN+1  number of mismatching vectors (max 2^N_IN)
first_fail  output  N_IN  vector of the first mismatch; valid when fail_valid
fail_valid  output  1  at least one mismatch recorded in current/last sweep

Behaviour:
- Reset: rst_n sampled low at a rising edge -> state IDLE; vec_out, busy, done, pass, err_count, first_fail, fail_valid, idx and settle counter all 0. Reset applies in any state, including mid-sweep; the sweep is abandoned with no done.
- All outputs are registered.
- FSM states:
  - IDLE: start=1 -> idx=0, vec_out=0, cnt=0, err_count=0, fail_valid=0, first_fail=0, done=0, busy=1 -> SETTLE.
  - SETTLE: cnt increments each cycle; cnt==SETTLE-1 -> CHECK.
  - CHECK: sample dut_f; mismatch if dut_f != TRUTH[vec_out].
    - On mismatch: err_count++; if fail_valid==0, first_fail=vec_out and fail_valid=1.
    - If idx==2^N_IN-1 -> DONE with busy=0, done=1, pass=(final err_count==0). The final comparison is included.
    - Otherwise idx++, vec_out=next vector, cnt=0 -> SETTLE.
  - DONE: holds all results. start=1 -> same actions as start in IDLE (restart).
- Start handling: start while busy is ignored, with no restart and no effect on results.
- Timing: each vector occupies exactly SETTLE+1 cycles, so a sweep takes 2^N_IN*(SETTLE+1) cycles from the start-accept edge to the done edge.
- Widths:
  - idx is N_IN+1 bits internally, so the last-vector compare does not wrap.
  - err_count cannot overflow: its ceiling is 2^N_IN, which fits in N_IN+1 bits.
- dut_f is treated as synchronous to clk; X on dut_f counts as a mismatch in simulation, because the comparison uses case-inequality semantics.

Optional Feature:
SWEEP_GRAY_EN
- Defined: vec_out steps in reflected Gray order, vec_out = idx ^ (idx>>1), so only one DUT input toggles per vector. The expected bit is TRUTH[vec_out], and first_fail reports the Gray vector, not idx.
- Undefined: binary order, vec_out = idx.
- Cycle counts and all other behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0, busy=0; release with no start -> state stays IDLE, outputs stay 0.
- Golden: N_IN=4, TRUTH=16'hA5C3, SETTLE=1, behavioural model F=TRUTH[vec], start pulse -> vec_out steps 0..15 every 2 cycles; done=1 exactly 32 cycles after start-accept; err_count=0, pass=1, fail_valid=0.
- Injected faults: same setup, model inverts F at vectors 5 and 11 -> err_count=2, first_fail=4'd5, fail_valid=1, pass=0.
- Stuck-at-0: dut_f tied 0, TRUTH=16'hA5C3 -> err_count=8, first_fail=4'd0, pass=0; with SETTLE=3, done arrives at 64 cycles.
- Control corners:
  - start re-pulsed at vector 7 -> ignored, sweep still ends at 32 cycles.
  - rst_n=0 at vector 9 -> IDLE, all outputs 0, done never asserts.
  - start in DONE -> results cleared on the accept edge; new sweep completes normally.
- Gray build (SWEEP_GRAY_EN defined), golden model -> vec_out sequence 0,1,3,2,6,7,5,4,12,...,8; exactly one bit changes per step; pass=1.
